s_axi_burst_mem: RTL and testbench

//  AXI4 slave with burst support and an internal word-addressed memory.
//  It sits directly downstream of the team's AXI4 burst master as its target.

---
 rtl/s_axi_burst_mem_pkg.sv | 19 +
 rtl/s_axi_burst_mem_if.sv | 64 ++++++
 rtl/s_axi_burst_mem_ram.sv | 34 +++
 rtl/s_axi_burst_mem.sv | 208 ++++++++++++++++++++
 tb/tb_s_axi_burst_mem.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/s_axi_burst_mem_pkg.sv
// Shared definitions for the s_axi_burst_mem slice.
//   AXI field widths and encodings used by the interface and the slave,
//   plus the write/read FSM state types.
// Configuration macro used elsewhere in the slice: AXI_SLV_ERR_CHECK_EN.
package s_axi_burst_mem_pkg;

  localparam int AXI_LEN_WIDTH   = 8;
  localparam int AXI_SIZE_WIDTH  = 3;
  localparam int AXI_BURST_WIDTH = 2;
  localparam int AXI_RESP_WIDTH  = 2;

  localparam logic [AXI_RESP_WIDTH-1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_WIDTH-1:0]  AXI_RESP_SLVERR = 2'b10;
  localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/s_axi_burst_mem_if.sv
// AXI4 bus bundle between the burst master and s_axi_burst_mem.
//   Channels: AW, W, B, AR, R (lock/cache/prot/qos/region not carried).
//   Modports: master (drives requests, W data, bready/rready) and
//             slave (drives readies, B and R responses).
// Configuration macro relevant to the slave: AXI_SLV_ERR_CHECK_EN.
interface s_axi_burst_mem_if
  import s_axi_burst_mem_pkg::*;
#(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ID_WIDTH-1:0]        awid;
  logic [ADDR_WIDTH-1:0]      awaddr;
  logic [AXI_LEN_WIDTH-1:0]   awlen;
  logic [AXI_SIZE_WIDTH-1:0]  awsize;
  logic [AXI_BURST_WIDTH-1:0] awburst;
  logic                       awvalid;
  logic                       awready;

  logic [DATA_WIDTH-1:0]      wdata;
  logic [DATA_WIDTH/8-1:0]    wstrb;
  logic                       wlast;
  logic                       wvalid;
  logic                       wready;

  logic [ID_WIDTH-1:0]        bid;
  logic [AXI_RESP_WIDTH-1:0]  bresp;
  logic                       bvalid;
  logic                       bready;

  logic [ID_WIDTH-1:0]        arid;
  logic [ADDR_WIDTH-1:0]      araddr;
  logic [AXI_LEN_WIDTH-1:0]   arlen;
  logic [AXI_SIZE_WIDTH-1:0]  arsize;
  logic [AXI_BURST_WIDTH-1:0] arburst;
  logic                       arvalid;
  logic                       arready;

  logic [ID_WIDTH-1:0]        rid;
  logic [DATA_WIDTH-1:0]      rdata;
  logic [AXI_RESP_WIDTH-1:0]  rresp;
  logic                       rlast;
  logic                       rvalid;
  logic                       rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/s_axi_burst_mem_ram.sv
// Word-addressed storage for s_axi_burst_mem.
//   clk   : clock
//   we    : write enable, one word per cycle
//   waddr : write word index;  wdata / wstrb : data and byte enables
//   raddr : read word index;   rdata : asynchronous read data
// A read of the word being written in the same cycle sees the old contents.
// Contents are never reset. Configuration macro in this slice: AXI_SLV_ERR_CHECK_EN (unused here).
module s_axi_burst_mem_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IDX_WIDTH-1:0]    waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [IDX_WIDTH-1:0]    raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/s_axi_burst_mem.sv
// AXI4 burst slave backed by an internal word-addressed memory.
//   s_axi_aclk   : clock
//   s_axi_areset : synchronous reset, active-high
//   bus          : AXI4 slave modport (AW, W, B, AR, R)
// One write burst and one read burst may be in flight at once, independently.
// All bursts are handled as full-width INCR; addresses alias modulo the depth.
// Optional macro AXI_SLV_ERR_CHECK_EN: answer SLVERR for out-of-range, top-crossing,
// non-INCR, narrow or wlast-inconsistent bursts (erroring writes store nothing,
// erroring reads return zero data on every beat).
module s_axi_burst_mem
  import s_axi_burst_mem_pkg::*;
#(
  parameter int S_AXI_ID_WIDTH   = 1,
  parameter int S_AXI_ADDR_WIDTH = 32,
  parameter int S_AXI_DATA_WIDTH = 32,
  parameter logic [S_AXI_ADDR_WIDTH-1:0] S_BASE_ADDR = S_AXI_ADDR_WIDTH'(32'h40000000),
  parameter int S_MEM_DEPTH      = 64
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_areset,
  s_axi_burst_mem_if.slave bus
);

  localparam int BYTE_SHIFT = $clog2(S_AXI_DATA_WIDTH / 8);
  localparam int IDX_W      = $clog2(S_MEM_DEPTH);
  localparam logic [AXI_SIZE_WIDTH-1:0] FULL_SIZE = AXI_SIZE_WIDTH'(BYTE_SHIFT);

  function automatic logic [IDX_W-1:0] to_index(input logic [S_AXI_ADDR_WIDTH-1:0] addr);
    logic [S_AXI_ADDR_WIDTH-1:0] off;
    off = addr - S_BASE_ADDR;
    return IDX_W'(off >> BYTE_SHIFT);
  endfunction

  // ready_en keeps both address readies low during reset and while reset is
  // being released, so the first ready appears the cycle after deassertion.
  logic ready_en;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [S_AXI_ID_WIDTH-1:0] w_id, r_id;
  logic [IDX_W-1:0]          w_idx, r_idx, rd_addr;
  logic [AXI_LEN_WIDTH-1:0]  w_len, w_cnt, r_len, r_beat;
  logic                      w_err, r_err, aw_err, ar_err, w_bad;
  logic [S_AXI_DATA_WIDTH-1:0] r_data, ram_rdata;
  logic awready, wready, bvalid, arready, rvalid;
  logic aw_hs, w_hs, ar_hs, r_hs, w_last_beat, r_last_beat;

  assign aw_hs       = bus.awvalid && awready;
  assign w_hs        = bus.wvalid && wready;
  assign ar_hs       = bus.arvalid && arready;
  assign r_hs        = rvalid && bus.rready;
  assign w_last_beat = (w_cnt == w_len);
  assign r_last_beat = (r_beat == r_len);

`ifdef AXI_SLV_ERR_CHECK_EN
  // Wider arithmetic so start word + len cannot wrap before the depth compare.
  function automatic logic burst_err(input logic [S_AXI_ADDR_WIDTH-1:0] addr,
                                     input logic [AXI_LEN_WIDTH-1:0] len,
                                     input logic [AXI_SIZE_WIDTH-1:0] size,
                                     input logic [AXI_BURST_WIDTH-1:0] burst);
    logic [S_AXI_ADDR_WIDTH:0] words;
    words = {1'b0, (addr - S_BASE_ADDR) >> BYTE_SHIFT};
    return (addr < S_BASE_ADDR)
        || (words + (S_AXI_ADDR_WIDTH+1)'(len) >= (S_AXI_ADDR_WIDTH+1)'(S_MEM_DEPTH))
        || (burst != AXI_BURST_INCR) || (size != FULL_SIZE);
  endfunction

  assign aw_err = burst_err(bus.awaddr, bus.awlen, bus.awsize, bus.awburst);
  assign ar_err = burst_err(bus.araddr, bus.arlen, bus.arsize, bus.arburst);
  // A wlast mismatch poisons the current beat and everything after it.
  assign w_bad  = w_err || (bus.wlast != w_last_beat);
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
  assign w_bad  = 1'b0;
`endif

  // Both FSM state registers; reset drops any burst in progress.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Write FSM next state and channel handshakes.
  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = ready_en;
        if (bus.awvalid && ready_en) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (bus.wvalid && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bus.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Read FSM next state; the idle state looks up the incoming address so the
  // first beat is registered on the AR handshake edge.
  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    rd_addr = IDX_W'(r_idx + 1'b1);
    case (r_state)
      R_IDLE: begin
        arready = ready_en;
        rd_addr = to_index(bus.araddr);
        if (bus.arvalid && ready_en) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (bus.rready && r_last_beat) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Write-side burst bookkeeping.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      ready_en <= 1'b0;
      w_id     <= '0;
      w_idx    <= '0;
      w_len    <= '0;
      w_cnt    <= '0;
      w_err    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (aw_hs) begin
        w_id  <= bus.awid;
        w_idx <= to_index(bus.awaddr);
        w_len <= bus.awlen;
        w_cnt <= '0;
        w_err <= aw_err;
      end else if (w_hs) begin
        w_idx <= w_idx + 1'b1;
        w_cnt <= w_cnt + 1'b1;
        w_err <= w_bad;
      end
    end
  end

  // Read-side bookkeeping and the registered read data; held while stalled.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_id   <= '0;
      r_idx  <= '0;
      r_len  <= '0;
      r_beat <= '0;
      r_err  <= 1'b0;
      r_data <= '0;
    end else if (ar_hs) begin
      r_id   <= bus.arid;
      r_idx  <= rd_addr;
      r_len  <= bus.arlen;
      r_beat <= '0;
      r_err  <= ar_err;
      r_data <= ar_err ? '0 : ram_rdata;
    end else if (r_hs && !r_last_beat) begin
      r_idx  <= rd_addr;
      r_beat <= r_beat + 1'b1;
      r_data <= r_err ? '0 : ram_rdata;
    end
  end

  s_axi_burst_mem_ram #(
    .DATA_WIDTH(S_AXI_DATA_WIDTH),
    .DEPTH     (S_MEM_DEPTH),
    .IDX_WIDTH (IDX_W)
  ) u_ram (
    .clk  (s_axi_aclk),
    .we   (w_hs && !w_bad),
    .waddr(w_idx),
    .wdata(bus.wdata),
    .wstrb(bus.wstrb),
    .raddr(rd_addr),
    .rdata(ram_rdata)
  );

  assign bus.awready = awready;
  assign bus.wready  = wready;
  assign bus.bvalid  = bvalid;
  assign bus.bid     = w_id;
  assign bus.bresp   = w_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign bus.arready = arready;
  assign bus.rvalid  = rvalid;
  assign bus.rid     = r_id;
  assign bus.rdata   = r_data;
  assign bus.rresp   = r_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign bus.rlast   = rvalid && r_last_beat;

endmodule

// File: tb/tb_s_axi_burst_mem.sv
// Directed testbench for s_axi_burst_mem.
//   Scenarios: reset, INCR write/read burst, byte strobes, read backpressure,
//   delayed bready, out-of-range aliasing, and reset in the middle of a write.
// Honors AXI_SLV_ERR_CHECK_EN when choosing the out-of-range expectations.
module tb_s_axi_burst_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  s_axi_burst_mem_if #(.ID_WIDTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  s_axi_burst_mem #(
    .S_AXI_ID_WIDTH(1), .S_AXI_ADDR_WIDTH(32), .S_AXI_DATA_WIDTH(32),
    .S_BASE_ADDR(32'h40000000), .S_MEM_DEPTH(64)
  ) dut (
    .s_axi_aclk  (clk),
    .s_axi_areset(rst),
    .bus         (bus)
  );

  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  logic [31:0] rd_data [256];
  logic        rd_last [256];
  logic        rd_id   [256];
  logic [1:0]  rd_resp [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [31:0] addr, input logic [7:0] len, input logic id,
                       output bit to);
    int n;
    to = 0;
    bus.awaddr = addr; bus.awlen = len; bus.awid = id;
    bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awvalid = 1'b1;
    n = 0;
    while (bus.awready !== 1'b1 && n < 50) begin tick(); n++; end
    if (bus.awready !== 1'b1) to = 1;
    else tick();
    bus.awvalid = 1'b0;
  endtask

  task automatic do_w(input int nbeats, input logic [7:0] len, output bit to);
    int n;
    to = 0;
    for (int i = 0; i < nbeats; i++) begin
      bus.wdata = wbuf[i]; bus.wstrb = sbuf[i];
      bus.wlast = (i == int'(len)); bus.wvalid = 1'b1;
      n = 0;
      while (bus.wready !== 1'b1 && n < 50) begin tick(); n++; end
      if (bus.wready !== 1'b1) begin to = 1; break; end
      tick();
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic do_b(input int delay, output logic [1:0] resp, output logic id,
                      output int held, output logic after, output bit to);
    int n;
    to = 0; held = 0; resp = 'x; id = 'x; after = 'x;
    bus.bready = 1'b0;
    n = 0;
    while (bus.bvalid !== 1'b1 && n < 50) begin tick(); n++; end
    if (bus.bvalid !== 1'b1) begin to = 1; return; end
    repeat (delay) begin
      if (bus.bvalid === 1'b1) held++;
      tick();
    end
    resp = bus.bresp; id = bus.bid;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    after = bus.bvalid;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic id,
                          input int delay, output logic [1:0] resp, output logic bid,
                          output int held, output logic after, output bit to);
    bit t1, t2, t3;
    do_aw(addr, len, id, t1);
    do_w(int'(len) + 1, len, t2);
    do_b(delay, resp, bid, held, after, t3);
    to = t1 | t2 | t3;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic id,
                         input bit toggle, output int nb, output int unstable,
                         output logic after, output bit to);
    int n;
    bit phase, hold_v;
    logic [31:0] hd;
    logic hl, hi;
    to = 0; nb = 0; unstable = 0; phase = 0; hold_v = 0; hd = '0; hl = 0; hi = 0;
    bus.araddr = addr; bus.arlen = len; bus.arid = id;
    bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    n = 0;
    while (bus.arready !== 1'b1 && n < 50) begin tick(); n++; end
    if (bus.arready !== 1'b1) begin to = 1; bus.arvalid = 1'b0; after = 'x; return; end
    tick();
    bus.arvalid = 1'b0;
    n = 0;
    while (nb < int'(len) + 1 && n < 200) begin
      if (hold_v && (bus.rvalid !== 1'b1 || bus.rdata !== hd || bus.rlast !== hl || bus.rid !== hi))
        unstable++;
      bus.rready = toggle ? phase : 1'b1;
      phase = ~phase;
      if (bus.rvalid === 1'b1 && bus.rready) begin
        rd_data[nb] = bus.rdata; rd_last[nb] = bus.rlast;
        rd_id[nb] = bus.rid; rd_resp[nb] = bus.rresp;
        nb++; hold_v = 0;
      end else if (bus.rvalid === 1'b1) begin
        hold_v = 1; hd = bus.rdata; hl = bus.rlast; hi = bus.rid;
      end
      tick(); n++;
    end
    bus.rready = 1'b0;
    if (nb < int'(len) + 1) to = 1;
    after = bus.rvalid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++; if (bus.awready !== 1'b0) begin bad++; $display("[TB] FAIL reset_awready_in_reset got=%b exp=0", bus.awready); end
    total++; if (bus.arready !== 1'b0) begin bad++; $display("[TB] FAIL reset_arready_in_reset got=%b exp=0", bus.arready); end
    rst = 1'b0;
    tick();
    total++; if (bus.awready !== 1'b1) begin bad++; $display("[TB] FAIL reset_awready got=%b exp=1", bus.awready); end
    total++; if (bus.arready !== 1'b1) begin bad++; $display("[TB] FAIL reset_arready got=%b exp=1", bus.arready); end
    total++; if (bus.bvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_bvalid got=%b exp=0", bus.bvalid); end
    total++; if (bus.rvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid got=%b exp=0", bus.rvalid); end
    total++; if (bus.wready !== 1'b0) begin bad++; $display("[TB] FAIL reset_wready got=%b exp=0", bus.wready); end
  endtask

  task automatic test_incr_burst();
    logic [1:0] resp; logic bid, after; int held, nb, uns; bit to;
    for (int i = 0; i < 16; i++) begin wbuf[i] = 32'(i); sbuf[i] = 4'hF; end
    do_write(32'h40000000, 8'd15, 1'b1, 0, resp, bid, held, after, to);
    total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL incr_write_timeout got=%b exp=0", to); end
    total++; if (resp !== 2'b00) begin bad++; $display("[TB] FAIL incr_bresp got=%b exp=00", resp); end
    total++; if (bid !== 1'b1) begin bad++; $display("[TB] FAIL incr_bid got=%b exp=1", bid); end
    total++; if (after !== 1'b0) begin bad++; $display("[TB] FAIL incr_single_b got=%b exp=0", after); end
    do_read(32'h40000000, 8'd15, 1'b1, 1'b0, nb, uns, after, to);
    total++; if (nb !== 16) begin bad++; $display("[TB] FAIL incr_read_beats got=%0d exp=16", nb); end
    for (int i = 0; i < nb; i++) begin
      total++; if (rd_data[i] !== 32'(i)) begin bad++; $display("[TB] FAIL incr_rdata[%0d] got=%h exp=%h", i, rd_data[i], 32'(i)); end
      total++; if (rd_last[i] !== (i == 15)) begin bad++; $display("[TB] FAIL incr_rlast[%0d] got=%b exp=%b", i, rd_last[i], (i == 15)); end
      total++; if (rd_id[i] !== 1'b1) begin bad++; $display("[TB] FAIL incr_rid[%0d] got=%b exp=1", i, rd_id[i]); end
      total++; if (rd_resp[i] !== 2'b00) begin bad++; $display("[TB] FAIL incr_rresp[%0d] got=%b exp=00", i, rd_resp[i]); end
    end
    total++; if (after !== 1'b0) begin bad++; $display("[TB] FAIL incr_rvalid_after got=%b exp=0", after); end
  endtask

  task automatic test_byte_strobe();
    logic [1:0] resp; logic bid, after; int held, nb, uns; bit to;
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'hF;
    do_write(32'h40000010, 8'd0, 1'b0, 0, resp, bid, held, after, to);
    wbuf[0] = 32'h11223344; sbuf[0] = 4'b0101;
    do_write(32'h40000010, 8'd0, 1'b0, 0, resp, bid, held, after, to);
    do_read(32'h40000010, 8'd0, 1'b0, 1'b0, nb, uns, after, to);
    total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL strobe_timeout got=%b exp=0", to); end
    total++; if (rd_data[0] !== 32'hAA22CC44) begin bad++; $display("[TB] FAIL strobe_rdata got=%h exp=aa22cc44", rd_data[0]); end
    total++; if (rd_last[0] !== 1'b1) begin bad++; $display("[TB] FAIL strobe_rlast got=%b exp=1", rd_last[0]); end
  endtask

  task automatic test_rready_toggle();
    logic after; int nb, uns; bit to;
    do_read(32'h40000020, 8'd7, 1'b0, 1'b1, nb, uns, after, to);
    total++; if (nb !== 8) begin bad++; $display("[TB] FAIL toggle_beats got=%0d exp=8", nb); end
    total++; if (uns !== 0) begin bad++; $display("[TB] FAIL toggle_unstable got=%0d exp=0", uns); end
    for (int i = 0; i < nb; i++) begin
      total++; if (rd_data[i] !== 32'(i + 8)) begin bad++; $display("[TB] FAIL toggle_rdata[%0d] got=%h exp=%h", i, rd_data[i], 32'(i + 8)); end
      total++; if (rd_last[i] !== (i == 7)) begin bad++; $display("[TB] FAIL toggle_rlast[%0d] got=%b exp=%b", i, rd_last[i], (i == 7)); end
    end
    total++; if (after !== 1'b0) begin bad++; $display("[TB] FAIL toggle_rvalid_after got=%b exp=0", after); end
  endtask

  task automatic test_bready_delay();
    logic [1:0] resp; logic bid, after; int held, nb, uns; bit to;
    wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
    do_write(32'h40000020, 8'd0, 1'b1, 5, resp, bid, held, after, to);
    total++; if (held !== 5) begin bad++; $display("[TB] FAIL bdelay_held got=%0d exp=5", held); end
    total++; if (after !== 1'b0) begin bad++; $display("[TB] FAIL bdelay_drop got=%b exp=0", after); end
    total++; if (bid !== 1'b1) begin bad++; $display("[TB] FAIL bdelay_bid got=%b exp=1", bid); end
    do_read(32'h40000020, 8'd0, 1'b0, 1'b0, nb, uns, after, to);
    total++; if (rd_data[0] !== 32'h12345678) begin bad++; $display("[TB] FAIL bdelay_rdata got=%h exp=12345678", rd_data[0]); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic bid, after; int held, nb, uns; bit to;
    logic [1:0] exp_resp; logic [31:0] exp_word0;
`ifdef AXI_SLV_ERR_CHECK_EN
    exp_resp = 2'b10; exp_word0 = 32'h00000000;
`else
    exp_resp = 2'b00; exp_word0 = 32'hDEADBEEF;
`endif
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    do_write(32'h40000100, 8'd0, 1'b0, 0, resp, bid, held, after, to);
    total++; if (resp !== exp_resp) begin bad++; $display("[TB] FAIL oor_bresp got=%b exp=%b", resp, exp_resp); end
    do_read(32'h40000000, 8'd0, 1'b0, 1'b0, nb, uns, after, to);
    total++; if (rd_data[0] !== exp_word0) begin bad++; $display("[TB] FAIL oor_word0 got=%h exp=%h", rd_data[0], exp_word0); end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] resp; logic bid, after; int held, nb, uns, bseen; bit to;
    for (int i = 0; i < 16; i++) begin wbuf[i] = 32'h100 + 32'(i); sbuf[i] = 4'hF; end
    do_aw(32'h40000000, 8'd15, 1'b0, to);
    do_w(5, 8'd15, to);
    rst = 1'b1;
    tick();
    total++; if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== 5'b0) begin
      bad++; $display("[TB] FAIL midrst_quiet got=%b exp=00000", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}); end
    tick();
    rst = 1'b0;
    tick();
    total++; if (bus.awready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_awready got=%b exp=1", bus.awready); end
    bseen = 0;
    repeat (5) begin if (bus.bvalid !== 1'b0) bseen++; tick(); end
    total++; if (bseen !== 0) begin bad++; $display("[TB] FAIL midrst_no_b got=%0d exp=0", bseen); end
    do_read(32'h40000000, 8'd5, 1'b0, 1'b0, nb, uns, after, to);
    for (int i = 0; i < 6; i++) begin
      total++; if (rd_data[i] !== ((i < 5) ? 32'h100 + 32'(i) : 32'd5)) begin
        bad++; $display("[TB] FAIL midrst_word[%0d] got=%h exp=%h", i, rd_data[i], ((i < 5) ? 32'h100 + 32'(i) : 32'd5)); end
    end
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hC0 + 32'(i); sbuf[i] = 4'hF; end
    do_write(32'h40000040, 8'd3, 1'b1, 0, resp, bid, held, after, to);
    total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL fresh_timeout got=%b exp=0", to); end
    total++; if (resp !== 2'b00) begin bad++; $display("[TB] FAIL fresh_bresp got=%b exp=00", resp); end
    do_read(32'h40000040, 8'd3, 1'b1, 1'b0, nb, uns, after, to);
    for (int i = 0; i < 4; i++) begin
      total++; if (rd_data[i] !== 32'hC0 + 32'(i)) begin bad++; $display("[TB] FAIL fresh_rdata[%0d] got=%h exp=%h", i, rd_data[i], 32'hC0 + 32'(i)); end
    end
  endtask

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    test_reset();
    test_incr_burst();
    test_byte_strobe();
    test_rready_toggle();
    test_bready_delay();
    test_out_of_range();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
